fifo_rd_adapter: RTL

Read-side adapter that drains the TRIX-V synchronous `fifo` and presents its contents as a valid/ready stream. It issues `rd_en` to the FIFO, absorbs the FIFO's one-cycle registered read latency in a 2-entry prefetch buffer, and guarantees in-order, loss-free delivery under arbitrary downstream back-pressure. It sits between any `fifo` instance and a stream consumer such as a fetch or load-store unit.

---
 rtl/fifo_rd_adapter_pkg.sv | 9 +
 rtl/fifo_rd_adapter_buf.sv | 57 +++++
 rtl/fifo_rd_adapter.sv | 60 ++++++
 3 files changed

// File: rtl/fifo_rd_adapter_pkg.sv
// Shared types and sizing for the FIFO read-side adapter.
package fifo_rd_adapter_pkg;

  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] occ_t;
  typedef logic       ptr_t;

endpackage

// File: rtl/fifo_rd_adapter_buf.sv
// Two-entry prefetch register buffer with head/tail pointers and occupancy count.
module fifo_rd_adapter_buf
  import fifo_rd_adapter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  occ_t             occ_q, occ_d;

  // Clear wins over push/pop so a beat landing in a flush cycle is dropped.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (clr_i) begin
      head_d = 1'b0;
      tail_d = 1'b0;
      occ_d  = '0;
    end else begin
      if (push_i) tail_d = ~tail_q;
      if (pop_i)  head_d = ~head_q;
      occ_d = occ_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[tail_q] <= push_data_i;
  end

  assign head_data_o = mem_q[head_q];
  assign occ_o       = occ_q;

endmodule

// File: rtl/fifo_rd_adapter.sv
// Drains a synchronous FIFO into a valid/ready stream through a 2-entry prefetch buffer.
// Optional macro FIFO_RD_ADAPTER_LOOKAHEAD_EN lets a same-cycle pop free a read credit.
module fifo_rd_adapter
  import fifo_rd_adapter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  input  logic             fifo_empty_i,
  output logic             fifo_rd_en_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [1:0]       occupancy_o
);

  // Stream handshake: a beat transfers on a rising edge where m_valid_o && m_ready_i;
  // once raised, m_valid_o and m_data_o hold until that transfer (flush/reset excepted).

  logic       infl_q, infl_d;
  occ_t       occ;
  logic       pop;
  logic       credit_ok;
  logic [2:0] owed;

  assign m_valid_o = (occ != 2'd0);
  assign pop       = m_valid_o && m_ready_i;
  assign owed      = {1'b0, occ} + {2'b00, infl_q};

`ifdef FIFO_RD_ADAPTER_LOOKAHEAD_EN
  assign credit_ok = (owed - {2'b00, pop}) < 3'd2;
`else
  assign credit_ok = owed < 3'd2;
`endif

  assign fifo_rd_en_o = !fifo_empty_i && !flush_i && !rst_i && credit_ok;
  assign infl_d       = fifo_rd_en_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) infl_q <= 1'b0;
    else       infl_q <= infl_d;
  end

  fifo_rd_adapter_buf #(.WIDTH(WIDTH)) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (flush_i),
    .push_i      (infl_q),
    .push_data_i (fifo_rdata_i),
    .pop_i       (pop),
    .head_data_o (m_data_o),
    .occ_o       (occ)
  );

  assign occupancy_o = occ;

endmodule
